vtage_provider_sel: RTL

- Sits directly downstream of the VTAGE bank array.
- Each cycle it takes the per-bank lookup results for every prediction lane and selects the provider: the highest-numbered bank that hits, with bank 0 (LVP base) always hitting.
- It registers the selected prediction and a "use" decision for the pipeline.
- It enqueues per-lookup metadata (provider, conf, useful, per-bank index/tag) into an in-flight queue, which the feedback/update path consumes in program order.

---
 rtl/vtage_provider_sel.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vtage_provider_sel.sv
// VTAGE provider selection: picks the highest hitting bank per lane, registers
// the prediction and use decision, and queues lookup metadata for update.
module vtage_provider_sel #(
  parameter int P_NUM_PRED    = 2,
  parameter int P_NUM_BANKS   = 4,
  parameter int P_NUM_ENTRIES = 256,
  parameter int P_VALUE_WIDTH = 32,
  parameter int P_CONF_WIDTH  = 8,
  parameter int P_CONF_THRESH = 2**(P_CONF_WIDTH+1)-1,
  parameter int P_TAG_WIDTH   = 8,
  parameter int P_U_WIDTH     = 2,
  parameter int P_Q_DEPTH     = 16,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES),
  localparam int LP_QW          = $clog2(P_Q_DEPTH),
  localparam int LP_BW          = $clog2(P_NUM_BANKS)
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
  input  logic [P_NUM_PRED-1:0]                                         lk_valid_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0]                        bank_hit_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]     bank_value_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_CONF_WIDTH:0]        bank_conf_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_U_WIDTH-1:0]         bank_useful_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]    bank_index_i,
  input  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]       bank_tag_i,
  output logic [P_NUM_PRED-1:0]                                         pred_valid_o,
  output logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]                      pred_value_o,
  output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]                         pred_conf_o,
  output logic [P_NUM_PRED-1:0]                                         pred_use_o,
  output logic [P_NUM_PRED-1:0][LP_BW-1:0]                              pred_provider_o,
  output logic                                                          meta_valid_o,
  output logic [P_NUM_PRED-1:0]                                         meta_lane_o,
  output logic [P_NUM_PRED-1:0][LP_BW-1:0]                              meta_provider_o,
  output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]                         meta_conf_o,
  output logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]                          meta_useful_o,
  output logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]    meta_index_o,
  output logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]       meta_tag_o,
  input  logic                                                          meta_pop_i,
  input  logic                                                          flush_i,
  output logic                                                          drop_o,
  output logic [LP_QW:0]                                                q_count_o
);

  localparam logic [P_CONF_WIDTH:0] LP_THRESH = (P_CONF_WIDTH+1)'(P_CONF_THRESH);
  localparam logic [LP_QW:0]        LP_FULL   = (LP_QW+1)'(P_Q_DEPTH);

  // Bank 0 is the base predictor and always hits, so its hit bits carry no information.
  logic unused_bank0_hit;
  assign unused_bank0_hit = ^bank_hit_i[0];

  logic [P_NUM_PRED-1:0][LP_BW-1:0]          sel_prov;
  logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]  sel_value;
  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]     sel_conf;
  logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]      sel_useful;
  logic [P_NUM_PRED-1:0]                     use_d;

  logic [LP_QW-1:0] wr_ptr_q;
  logic [LP_QW-1:0] rd_ptr_q;
  logic [LP_QW:0]   count_q;

  logic push;
  logic full;
  logic empty;
  logic accept;
  logic pop_eff;
  logic drop_d;

  logic [P_NUM_PRED-1:0]                                      q_lane   [P_Q_DEPTH];
  logic [P_NUM_PRED-1:0][LP_BW-1:0]                           q_prov   [P_Q_DEPTH];
  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]                      q_conf   [P_Q_DEPTH];
  logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]                       q_useful [P_Q_DEPTH];
  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] q_index  [P_Q_DEPTH];
  logic [P_NUM_BANKS-1:0][P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]    q_tag    [P_Q_DEPTH];

  // Queue handshake: flush overrides everything, a pop frees a slot for a same-cycle push when full.
  assign push    = |lk_valid_i;
  assign full    = (count_q == LP_FULL);
  assign empty   = (count_q == '0);
  assign accept  = push & (~full | meta_pop_i) & ~flush_i;
  assign pop_eff = meta_pop_i & ~empty & ~flush_i;
  assign drop_d  = push & full & ~meta_pop_i & ~flush_i;

  // Per lane, the last (highest) hitting bank above the base wins; then mux its fields.
  always_comb begin
    sel_prov   = '0;
    sel_value  = '0;
    sel_conf   = '0;
    sel_useful = '0;
    use_d      = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      for (int b = 1; b < P_NUM_BANKS; b++) begin
        if (bank_hit_i[b][l]) sel_prov[l] = LP_BW'(b);
      end
      sel_value[l]  = bank_value_i[sel_prov[l]][l];
      sel_conf[l]   = bank_conf_i[sel_prov[l]][l];
      sel_useful[l] = bank_useful_i[sel_prov[l]][l];
      use_d[l]      = lk_valid_i[l] & accept & (sel_conf[l] >= LP_THRESH);
    end
  end

  // Prediction output stage, pointers, occupancy and the drop pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o    <= '0;
      pred_value_o    <= '0;
      pred_conf_o     <= '0;
      pred_use_o      <= '0;
      pred_provider_o <= '0;
      drop_o          <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      pred_valid_o    <= lk_valid_i & {P_NUM_PRED{accept}};
      pred_value_o    <= sel_value;
      pred_conf_o     <= sel_conf;
      pred_use_o      <= use_d;
      pred_provider_o <= sel_prov;
      drop_o          <= drop_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (accept)  wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + (LP_QW+1)'(accept) - (LP_QW+1)'(pop_eff);
      end
    end
  end

  // Metadata storage has no reset; only slots below the occupancy count are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      q_lane[wr_ptr_q]   <= lk_valid_i;
      q_prov[wr_ptr_q]   <= sel_prov;
      q_conf[wr_ptr_q]   <= sel_conf;
      q_useful[wr_ptr_q] <= sel_useful;
      q_index[wr_ptr_q]  <= bank_index_i;
      q_tag[wr_ptr_q]    <= bank_tag_i;
    end
  end

  assign meta_valid_o    = ~empty;
  assign meta_lane_o     = q_lane[rd_ptr_q];
  assign meta_provider_o = q_prov[rd_ptr_q];
  assign meta_conf_o     = q_conf[rd_ptr_q];
  assign meta_useful_o   = q_useful[rd_ptr_q];
  assign meta_index_o    = q_index[rd_ptr_q];
  assign meta_tag_o      = q_tag[rd_ptr_q];
  assign q_count_o       = count_q;

endmodule
